capture_control: RTL

- Sits directly downstream of the trigger block, between the sampled input bus and the host readout path.
- Continuously writes valid samples into a circular sample RAM.
- Pulses arm to the trigger once the requested pre-trigger history has been collected, then reacts to the trigger's run output by capturing a fixed number of post-trigger samples.
- After capture, streams the pre+post window out oldest-first over a valid/ready handshake.

---
 rtl/la_capture_pkg.sv | 23 ++
 rtl/sample_ram.sv | 24 ++
 rtl/capture_control.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/la_capture_pkg.sv
// Shared types for the logic-analyser capture path.
// Optional trigger timestamp is enabled by CAPTURE_TIMESTAMP_EN.
package la_capture_pkg;

  localparam int SAMPLE_W = 8;
  localparam int ADDR_W   = 10;

  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    WAIT_TRIG,
    POST,
    READOUT
  } cap_state_t;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [ADDR_W-1:0]   addr_t;

  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Circular sample store: one write port, one read port.
// Read data appears one clock after the address.
module sample_ram
  import la_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                    clock,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [SAMPLE_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [SAMPLE_WIDTH-1:0] rdata
);

  logic [SAMPLE_WIDTH-1:0] mem [depth(ADDR_WIDTH)];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_control.sv
// Pre/post-trigger capture sequencer with oldest-first streaming readout.
// Define CAPTURE_TIMESTAMP_EN to add the trig_time output.
module capture_control
  import la_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    valid,
  input  logic [SAMPLE_WIDTH-1:0] dataIn,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   pre_count,
  input  logic [ADDR_WIDTH:0]     post_count,
  input  logic                    run,
  output logic                    arm,
  output logic                    busy,
  output logic                    done,
  output logic [SAMPLE_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
`ifdef CAPTURE_TIMESTAMP_EN
  ,
  output logic [31:0]             trig_time
`endif
);

  localparam int CW = ADDR_WIDTH + 1;
  typedef logic [CW-1:0]           cnt_t;
  typedef logic [ADDR_WIDTH-1:0]   ptr_t;
  typedef logic [SAMPLE_WIDTH-1:0] smp_t;

  localparam cnt_t DEPTH_C = cnt_t'(depth(ADDR_WIDTH));
  localparam cnt_t C1      = cnt_t'(1);
  localparam cnt_t MAXPRE  = DEPTH_C - C1;
  localparam ptr_t P1      = ptr_t'(1);

  cap_state_t state, state_n;
  ptr_t wptr, rd_addr;
  cnt_t pre_eff, post_eff, total;
  cnt_t fill_cnt, post_cnt, issued;
  cnt_t pre_in, pre_clip, room, post_clip;
  logic run_pend, wr_en, trig, go, pop, issue;
  logic inflight, infl_last, frp, fwp;
  logic [1:0] fcnt, occ;
  smp_t ram_q;
  smp_t fdata [2];
  logic flast [2];

  always_comb begin
    pre_in    = {1'b0, pre_count};
    pre_clip  = (pre_in > MAXPRE) ? MAXPRE : pre_in;
    room      = DEPTH_C - pre_clip;
    post_clip = (post_count < room) ? post_count : room;
    if (post_clip == '0) post_clip = C1;
  end

  assign go    = (state == IDLE) && start && !abort;
  assign wr_en = valid && ((state == PREFILL) ||
                 (state == WAIT_TRIG) || (state == POST));
  assign trig  = (state == WAIT_TRIG) && valid && (run || run_pend);
  assign pop   = out_valid && out_ready;
  assign occ   = fcnt + {1'b0, inflight};
  assign issue = (state == READOUT) && !abort &&
                 (issued != total) && ((occ < 2'd2) || pop);

  assign busy      = (state != IDLE);
  assign done      = (state == READOUT);
  assign out_valid = (fcnt != 2'd0);
  assign out_data  = fdata[frp];
  assign out_last  = flast[frp];

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (start) state_n = PREFILL;
      PREFILL:   if (fill_cnt == pre_eff) state_n = WAIT_TRIG;
      WAIT_TRIG: if (trig) state_n = (post_eff == C1) ? READOUT : POST;
      POST:      if (valid && (post_cnt + C1 == post_eff)) state_n = READOUT;
      READOUT:   if (pop && out_last) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      arm       <= 1'b0;
      wptr      <= '0;
      rd_addr   <= '0;
      pre_eff   <= '0;
      post_eff  <= '0;
      total     <= '0;
      fill_cnt  <= '0;
      post_cnt  <= '0;
      issued    <= '0;
      run_pend  <= 1'b0;
      inflight  <= 1'b0;
      infl_last <= 1'b0;
      fcnt      <= '0;
      frp       <= 1'b0;
      fwp       <= 1'b0;
      fdata[0]  <= '0;
      fdata[1]  <= '0;
      flast[0]  <= 1'b0;
      flast[1]  <= 1'b0;
    end else begin
      state    <= state_n;
      arm      <= (state_n == WAIT_TRIG) && (state != WAIT_TRIG);
      run_pend <= (state == WAIT_TRIG) && !trig && (run_pend || run);
      if (wr_en) wptr <= wptr + P1;
      if (go) begin
        pre_eff  <= pre_clip;
        post_eff <= post_clip;
        total    <= pre_clip + post_clip;
        fill_cnt <= '0;
      end else if ((state == PREFILL) && valid && (fill_cnt != pre_eff)) begin
        fill_cnt <= fill_cnt + C1;
      end
      // Window start is pre_eff samples behind the trigger write
      if (trig) begin
        post_cnt <= C1;
        rd_addr  <= wptr - pre_eff[ADDR_WIDTH-1:0];
      end else if ((state == POST) && valid) begin
        post_cnt <= post_cnt + C1;
      end
      if ((state != READOUT) || abort) begin
        issued   <= '0;
        inflight <= 1'b0;
        fcnt     <= '0;
        frp      <= 1'b0;
        fwp      <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) begin
          rd_addr   <= rd_addr + P1;
          issued    <= issued + C1;
          infl_last <= (issued == total - C1);
        end
        if (inflight) begin
          fdata[fwp] <= ram_q;
          flast[fwp] <= infl_last;
          fwp        <= ~fwp;
        end
        if (pop) frp <= ~frp;
        fcnt <= fcnt + {1'b0, inflight} - {1'b0, pop};
      end
    end
  end

`ifdef CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_cnt    <= '0;
      trig_time <= '0;
    end else begin
      if ((state_n == WAIT_TRIG) && (state != WAIT_TRIG)) ts_cnt <= '0;
      else if (valid && (ts_cnt != '1)) ts_cnt <= ts_cnt + 32'd1;
      if (go) trig_time <= '0;
      else if (trig) trig_time <= ts_cnt;
    end
  end
`endif

  sample_ram #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_ram (
    .clock (clock),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (dataIn),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

endmodule
